// File: rtl/sr_latch_nand_if.sv
// sr_latch_nand_if: set/reset request and latch status bundle for a bank of NAND SR latches
interface sr_latch_nand_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;
  logic [WIDTH-1:0] illegal;
  logic illegal_seen;
  modport master (output S, R, input Q, Qn, illegal, illegal_seen);
  modport slave (input S, R, output Q, Qn, illegal, illegal_seen);
endinterface

// File: rtl/sr_latch_nand.sv
// sr_latch_nand: clocked bank of active-low NAND SR latches with forbidden-state reporting
module sr_latch_nand #(parameter int WIDTH = 1) (
  input logic clk,
  input logic rst_n,
  sr_latch_nand_if.slave bus
);
  logic [WIDTH-1:0] q_state;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] qn_nx;
  logic [WIDTH-1:0] ill_nx;
  logic [WIDTH-1:0] qn_r;
  logic [WIDTH-1:0] ill_r;
  logic seen_r;
  // q_state is Q with the forbidden state folded to 0, so a hold after forbidden recovers reset-dominant
  always_comb begin
    q_nx = ~bus.S | (bus.R & q_state);
    qn_nx = ~bus.R | (bus.S & (qn_r | ill_r));
    ill_nx = ~bus.S & ~bus.R;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_state <= '0;
      qn_r <= '1;
      ill_r <= '0;
      seen_r <= 1'b0;
    end else begin
      q_state <= q_nx & ~ill_nx;
      qn_r <= qn_nx;
      ill_r <= ill_nx;
      seen_r <= seen_r | (|ill_nx);
    end
  end
  assign bus.Q = q_state | ill_r;
  assign bus.Qn = qn_r;
  assign bus.illegal = ill_r;
  assign bus.illegal_seen = seen_r;
endmodule

// File: tb/tb_sr_latch_nand.sv
// tb_sr_latch_nand: directed and randomized checks against a truth-table latch model
module tb_sr_latch_nand;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] mq, mqn, mill;
  logic mseen;
  sr_latch_nand_if #(.WIDTH(W)) bus ();
  sr_latch_nand #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic model_edge();
    if (!rst_n) begin
      mq = '0; mqn = '1; mill = '0; mseen = 1'b0;
    end else begin
      for (int i = 0; i < W; i++) begin
        case ({bus.S[i], bus.R[i]})
          2'b01: begin mq[i] = 1'b1; mqn[i] = 1'b0; mill[i] = 1'b0; end
          2'b10: begin mq[i] = 1'b0; mqn[i] = 1'b1; mill[i] = 1'b0; end
          2'b11: begin
            if (mill[i]) begin mq[i] = 1'b0; mqn[i] = 1'b1; end
            mill[i] = 1'b0;
          end
          default: begin mq[i] = 1'b1; mqn[i] = 1'b1; mill[i] = 1'b1; mseen = 1'b1; end
        endcase
      end
    end
  endtask

  task automatic tick(input logic rn, input logic [W-1:0] s, input logic [W-1:0] r);
    @(negedge clk);
    rst_n = rn; bus.S = s; bus.R = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, '0, '0);
    checks++;
    if ({bus.Q, bus.Qn, bus.illegal, bus.illegal_seen} !== {4'h0, 4'hf, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset got Q=%b Qn=%b ill=%b seen=%b", bus.Q, bus.Qn, bus.illegal, bus.illegal_seen);
    end
  endtask

  task automatic test_set_hold();
    tick(1'b1, 4'hf, 4'hf);
    tick(1'b1, 4'he, 4'hf);
    checks++;
    if ({bus.Q[0], bus.Qn[0], bus.illegal[0]} !== 3'b100) begin
      errors++; $display("FAIL set got Q=%b Qn=%b ill=%b want Q0=1 Qn0=0", bus.Q, bus.Qn, bus.illegal);
    end
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 4'hf, 4'hf);
      checks++;
      if ({bus.Q[0], bus.Qn[0]} !== 2'b10) begin
        errors++; $display("FAIL set_hold%0d got Q=%b Qn=%b want Q0=1 Qn0=0", k, bus.Q, bus.Qn);
      end
    end
  endtask

  task automatic test_reset_hold();
    tick(1'b1, 4'hf, 4'he);
    checks++;
    if ({bus.Q[0], bus.Qn[0]} !== 2'b01) begin
      errors++; $display("FAIL clear got Q=%b Qn=%b want Q0=0 Qn0=1", bus.Q, bus.Qn);
    end
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 4'hf, 4'hf);
      checks++;
      if ({bus.Q[0], bus.Qn[0]} !== 2'b01) begin
        errors++; $display("FAIL clear_hold%0d got Q=%b Qn=%b want Q0=0 Qn0=1", k, bus.Q, bus.Qn);
      end
    end
    tick(1'b1, 4'he, 4'hf);
    checks++;
    if ({bus.Q[0], bus.Qn[0], bus.illegal[0]} !== 3'b100) begin
      errors++; $display("FAIL set_after_clear got Q=%b Qn=%b ill=%b", bus.Q, bus.Qn, bus.illegal);
    end
  endtask

  task automatic test_forbidden();
    tick(1'b1, 4'he, 4'he);
    checks++;
    if ({bus.Q[0], bus.Qn[0], bus.illegal, bus.illegal_seen} !== {2'b11, 4'b0001, 1'b1}) begin
      errors++; $display("FAIL forbidden got Q=%b Qn=%b ill=%b seen=%b", bus.Q, bus.Qn, bus.illegal, bus.illegal_seen);
    end
    tick(1'b1, 4'hf, 4'hf);
    checks++;
    if ({bus.Q[0], bus.Qn[0], bus.illegal, bus.illegal_seen} !== {2'b01, 4'b0000, 1'b1}) begin
      errors++; $display("FAIL recover got Q=%b Qn=%b ill=%b seen=%b", bus.Q, bus.Qn, bus.illegal, bus.illegal_seen);
    end
    tick(1'b0, 4'hf, 4'hf);
    checks++;
    if (bus.illegal_seen !== 1'b0) begin
      errors++; $display("FAIL seen_clear got %b want 0", bus.illegal_seen);
    end
  endtask

  task automatic test_sampling();
    tick(1'b1, 4'hf, 4'hf);
    @(negedge clk);
    bus.S = 4'he;
    #2 bus.S = 4'hf;
    @(posedge clk);
    model_edge();
    #1;
    checks++;
    if (bus.Q[0] !== 1'b0) begin
      errors++; $display("FAIL glitch got Q0=%b want 0", bus.Q[0]);
    end
    @(negedge clk);
    #4 bus.S = 4'he;
    checks++;
    if (bus.Q[0] !== 1'b0) begin
      errors++; $display("FAIL pre_edge got Q0=%b want 0", bus.Q[0]);
    end
    @(posedge clk);
    model_edge();
    #1;
    checks++;
    if (bus.Q[0] !== 1'b1) begin
      errors++; $display("FAIL post_edge got Q0=%b want 1", bus.Q[0]);
    end
  endtask

  task automatic test_multibit();
    logic [1:0] hq, hqn;
    tick(1'b1, 4'b0111, 4'b1011);
    hq = bus.Q[3:2]; hqn = bus.Qn[3:2];
    tick(1'b1, 4'b1110, 4'b1101);
    checks++;
    if ({bus.Q, bus.Qn} !== {hq, 2'b01, hqn, 2'b10}) begin
      errors++; $display("FAIL multi_sr got Q=%b Qn=%b want Q=%b01 Qn=%b10", bus.Q, bus.Qn, hq, hqn);
    end
    tick(1'b1, 4'b0111, 4'b0111);
    checks++;
    if ({bus.Q, bus.Qn, bus.illegal} !== {1'b1, hq[0], 2'b01, 1'b1, hqn[0], 2'b10, 4'b1000}) begin
      errors++; $display("FAIL multi_forbid got Q=%b Qn=%b ill=%b", bus.Q, bus.Qn, bus.illegal);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      tick(($urandom_range(0, 19) != 0), W'($urandom), W'($urandom));
      checks++;
      if ({bus.Q, bus.Qn, bus.illegal, bus.illegal_seen} !== {mq, mqn, mill, mseen}) begin
        errors++;
        $display("FAIL random%0d got Q=%b Qn=%b ill=%b seen=%b want Q=%b Qn=%b ill=%b seen=%b",
          k, bus.Q, bus.Qn, bus.illegal, bus.illegal_seen, mq, mqn, mill, mseen);
      end
    end
  endtask

  initial begin
    bus.S = '1; bus.R = '1;
    mq = '0; mqn = '1; mill = '0; mseen = 1'b0;
    test_reset();
    test_set_hold();
    test_reset_hold();
    test_forbidden();
    test_sampling();
    test_multibit();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
